// File: rtl/fetch_unit.sv
// fetch_unit: tiny16 fetch stage; issues one memory read per instruction and
// hands the captured word to the decoder over valid/ready, with branch redirect.
module fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  mem_out_en,
  output logic [ADDR_WIDTH-1:0] mem_out_addr,
  input  logic [DATA_WIDTH-1:0] mem_out_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr
);
  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] pc;
  always_ff @(posedge clk)
    if (rst) state <= ISSUE;
    else     state <= state_nx;
  always_comb
    state_nx = branch_en          ? ISSUE :
               state == ISSUE     ? (mem_out_en ? CAPTURE : ISSUE) :
               state == CAPTURE   ? HOLD :
               !instr_ready       ? HOLD :
               mem_out_en         ? CAPTURE : ISSUE;
  // HOLD issues the next read during the handshake cycle for back-to-back fetch
  always_comb begin
    mem_out_en   = ~rst & run & ~branch_en &
                   (state == ISSUE | (state == HOLD & instr_ready));
    mem_out_addr = pc;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else if (branch_en) begin
      pc          <= branch_addr;
      instr_valid <= 1'b0;
    end else if (state == CAPTURE) begin
      instr_data  <= mem_out_data;
      instr_pc    <= pc;
      pc          <= pc + ADDR_WIDTH'(1);
      instr_valid <= 1'b1;
    end else if (state == HOLD & instr_ready) begin
      instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with behavioural sync-read memories.
module tb_fetch_unit;
  logic        clk = 0, rst, run, instr_ready, branch_en;
  logic [15:0] branch_addr;
  logic        mem_out_en, instr_valid, w_en, w_valid;
  logic [15:0] mem_out_addr, instr_data, instr_pc, rdata;
  logic [15:0] w_addr, w_data, w_pc, w_rdata;
  logic [15:0] mem [0:65535];
  int n = 0, errs = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_out_en(mem_out_en), .mem_out_addr(mem_out_addr), .mem_out_data(rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .branch_en(branch_en), .branch_addr(branch_addr)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .run(run),
    .mem_out_en(w_en), .mem_out_addr(w_addr), .mem_out_data(w_rdata),
    .instr_valid(w_valid), .instr_ready(instr_ready),
    .instr_data(w_data), .instr_pc(w_pc),
    .branch_en(branch_en), .branch_addr(branch_addr)
  );

  always @(posedge clk) if (mem_out_en) rdata <= mem[mem_out_addr];
  always @(posedge clk)
    if (w_en) w_rdata <= w_addr == 16'hFFFF ? 16'hAAAA : w_addr == 16'h0000 ? 16'h5555 : 16'hDEAD;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1; run = 1; instr_ready = 1; branch_en = 0; branch_addr = 0;
    #1;
    n++; if (mem_out_en !== 1'b0) begin errs++; $display("FAIL reset_en0: got %b exp 0", mem_out_en); end
    tick;
    n++; if ({mem_out_en, instr_valid, instr_data, instr_pc} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL reset_regs: got %b %b %h %h exp 0 0 0000 0000", mem_out_en, instr_valid, instr_data, instr_pc);
    end
    tick;
    n++; if ({mem_out_en, mem_out_addr} !== {1'b0, 16'h0}) begin
      errs++; $display("FAIL reset_en1: got %b %h exp 0 0000", mem_out_en, mem_out_addr);
    end
  endtask

  task automatic test_linear;
    rst = 0;
    #1;
    n++; if ({mem_out_en, mem_out_addr} !== {1'b1, 16'h0}) begin
      errs++; $display("FAIL lin_issue0: got %b %h exp 1 0000", mem_out_en, mem_out_addr);
    end
    tick;
    n++; if ({instr_valid, mem_out_en} !== 2'b00) begin
      errs++; $display("FAIL lin_capture0: got valid %b en %b exp 0 0", instr_valid, mem_out_en);
    end
    tick;
    n++; if ({instr_valid, instr_data, instr_pc, mem_out_en, mem_out_addr} !== {1'b1, 16'h1111, 16'h0, 1'b1, 16'h1}) begin
      errs++; $display("FAIL lin_i0: got %b %h %h en %b %h exp 1 1111 0000 en 1 0001", instr_valid, instr_data, instr_pc, mem_out_en, mem_out_addr);
    end
    tick;
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL lin_gap1: got %b exp 0", instr_valid); end
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h2222, 16'h1}) begin
      errs++; $display("FAIL lin_i1: got %b %h %h exp 1 2222 0001", instr_valid, instr_data, instr_pc);
    end
    tick;
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL lin_gap2: got %b exp 0", instr_valid); end
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h3333, 16'h2}) begin
      errs++; $display("FAIL lin_i2: got %b %h %h exp 1 3333 0002", instr_valid, instr_data, instr_pc);
    end
  endtask

  task automatic test_backpressure;
    instr_ready = 0; run = 1;
    do_reset;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      n++; if ({instr_valid, instr_data, instr_pc, mem_out_en} !== {1'b1, 16'h1111, 16'h0, 1'b0}) begin
        errs++; $display("FAIL bp_hold%0d: got %b %h %h en %b exp 1 1111 0000 en 0", i, instr_valid, instr_data, instr_pc, mem_out_en);
      end
      tick;
      #1;
    end
    instr_ready = 1;
    #1;
    n++; if ({mem_out_en, mem_out_addr} !== {1'b1, 16'h1}) begin
      errs++; $display("FAIL bp_release: got %b %h exp 1 0001", mem_out_en, mem_out_addr);
    end
    tick;
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h2222, 16'h1}) begin
      errs++; $display("FAIL bp_next: got %b %h %h exp 1 2222 0001", instr_valid, instr_data, instr_pc);
    end
  endtask

  task automatic test_branch_mid;
    instr_ready = 1; run = 1;
    do_reset;
    tick;
    branch_en = 1; branch_addr = 16'h0040;
    #1;
    n++; if (mem_out_en !== 1'b0) begin errs++; $display("FAIL brm_en: got %b exp 0", mem_out_en); end
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL brm_drop: got %b %h %h exp 0 0000 0000", instr_valid, instr_data, instr_pc);
    end
    branch_en = 0;
    #1;
    n++; if ({mem_out_en, mem_out_addr} !== {1'b1, 16'h0040}) begin
      errs++; $display("FAIL brm_issue: got %b %h exp 1 0040", mem_out_en, mem_out_addr);
    end
    tick;
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL brm_gap: got %b exp 0", instr_valid); end
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'hBEEF, 16'h0040}) begin
      errs++; $display("FAIL brm_target: got %b %h %h exp 1 beef 0040", instr_valid, instr_data, instr_pc);
    end
    tick;
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'hC0DE, 16'h0041}) begin
      errs++; $display("FAIL brm_follow: got %b %h %h exp 1 c0de 0041", instr_valid, instr_data, instr_pc);
    end
  endtask

  task automatic test_branch_handshake;
    instr_ready = 1; branch_en = 1; branch_addr = 16'h0010;
    #1;
    n++; if (mem_out_en !== 1'b0) begin errs++; $display("FAIL brh_en: got %b exp 0", mem_out_en); end
    tick;
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL brh_valid: got %b exp 0", instr_valid); end
    branch_en = 0;
    #1;
    n++; if ({mem_out_en, mem_out_addr} !== {1'b1, 16'h0010}) begin
      errs++; $display("FAIL brh_issue: got %b %h exp 1 0010", mem_out_en, mem_out_addr);
    end
    tick;
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h1234, 16'h0010}) begin
      errs++; $display("FAIL brh_target: got %b %h %h exp 1 1234 0010", instr_valid, instr_data, instr_pc);
    end
  endtask

  task automatic test_wrap;
    instr_ready = 1; run = 1;
    do_reset;
    n++; if ({w_en, w_addr} !== {1'b1, 16'hFFFF}) begin
      errs++; $display("FAIL wrap_issue: got %b %h exp 1 ffff", w_en, w_addr);
    end
    tick;
    tick;
    n++; if ({w_valid, w_data, w_pc} !== {1'b1, 16'hAAAA, 16'hFFFF}) begin
      errs++; $display("FAIL wrap_i0: got %b %h %h exp 1 aaaa ffff", w_valid, w_data, w_pc);
    end
    tick;
    tick;
    n++; if ({w_valid, w_data, w_pc} !== {1'b1, 16'h5555, 16'h0000}) begin
      errs++; $display("FAIL wrap_i1: got %b %h %h exp 1 5555 0000", w_valid, w_data, w_pc);
    end
  endtask

  task automatic test_reset_mid;
    instr_ready = 1; run = 1;
    do_reset;
    tick;
    rst = 1;
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL rstm_clear: got %b %h %h exp 0 0000 0000", instr_valid, instr_data, instr_pc);
    end
    rst = 0;
    #1;
    n++; if ({mem_out_en, mem_out_addr} !== {1'b1, 16'h0}) begin
      errs++; $display("FAIL rstm_restart: got %b %h exp 1 0000", mem_out_en, mem_out_addr);
    end
    tick;
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rstm_gap: got %b exp 0", instr_valid); end
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h1111, 16'h0}) begin
      errs++; $display("FAIL rstm_i0: got %b %h %h exp 1 1111 0000", instr_valid, instr_data, instr_pc);
    end
  endtask

  task automatic test_run_gating;
    instr_ready = 1; run = 0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      n++; if ({mem_out_en, instr_valid} !== 2'b00) begin
        errs++; $display("FAIL run_off%0d: got en %b valid %b exp 0 0", i, mem_out_en, instr_valid);
      end
      tick;
      #1;
    end
    run = 1;
    #1;
    n++; if (mem_out_en !== 1'b1) begin errs++; $display("FAIL run_on: got %b exp 1", mem_out_en); end
    tick;
    tick;
    n++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h1111, 16'h0}) begin
      errs++; $display("FAIL run_i0: got %b %h %h exp 1 1111 0000", instr_valid, instr_data, instr_pc);
    end
    run = 0; instr_ready = 0;
    tick;
    n++; if ({instr_valid, instr_data, mem_out_en} !== {1'b1, 16'h1111, 1'b0}) begin
      errs++; $display("FAIL run_keep: got %b %h en %b exp 1 1111 en 0", instr_valid, instr_data, mem_out_en);
    end
    instr_ready = 1;
    #1;
    n++; if (mem_out_en !== 1'b0) begin errs++; $display("FAIL run_hs_en: got %b exp 0", mem_out_en); end
    tick;
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL run_hs_valid: got %b exp 0", instr_valid); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'hDEAD;
    mem[16'h0000] = 16'h1111;
    mem[16'h0001] = 16'h2222;
    mem[16'h0002] = 16'h3333;
    mem[16'h0010] = 16'h1234;
    mem[16'h0040] = 16'hBEEF;
    mem[16'h0041] = 16'hC0DE;
    @(negedge clk);
    test_reset;
    test_linear;
    test_backpressure;
    test_branch_mid;
    test_branch_handshake;
    test_wrap;
    test_reset_mid;
    test_run_gating;
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the tiny16 core. It sits directly upstream of the decoder and drives the read port of `memory` (`out_en`, `out_addr`, `out_data`). It holds the program counter, issues one word read per instruction, captures the returned word, and presents it to the decoder with a valid/ready handshake. It also accepts branch redirects from execute, which flush any fetch in flight.

## Interface

Parameters:
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `ADDR_WIDTH`, 16: word address width; matches `memory`.
- `DATA_WIDTH`, 16: instruction word width.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `run`  input  1  fetch enable; 0 blocks new reads from being issued.
- `mem_out_en`  output  1  connects to `memory.out_en`.
- `mem_out_addr`  output  ADDR_WIDTH  connects to `memory.out_addr`.
- `mem_out_data`  input  DATA_WIDTH  connects to `memory.out_data`; valid the cycle after `mem_out_en` is sampled.
- `instr_valid`  output  1  `instr_data`/`instr_pc` hold a fetched instruction.
- `instr_ready`  input  1  decoder accepts the instruction at this edge.
- `instr_data`  output  DATA_WIDTH  fetched instruction word.
- `instr_pc`  output  ADDR_WIDTH  address the instruction was fetched from.
- `branch_en`  input  1  redirect request from execute.
- `branch_addr`  input  ADDR_WIDTH  redirect target.

## Operation

State machine with three states: ISSUE, CAPTURE, HOLD. It resets to ISSUE.

- **ISSUE**
  - `mem_out_en = run & ~branch_en`, `mem_out_addr = pc`.
  - If `mem_out_en` is 1 → CAPTURE; otherwise stay in ISSUE.
- **CAPTURE**
  - Read data is present on `mem_out_data`.
  - At the edge: `instr_data <= mem_out_data`, `instr_pc <= pc`, `pc <= pc + 1`, `instr_valid <= 1` → HOLD.
  - The increment is modulo 2^ADDR_WIDTH, so 16'hFFFF wraps to 16'h0000.
- **HOLD**
  - `instr_valid = 1`; outputs are stable until the handshake completes.
  - `mem_out_en = instr_ready & run & ~branch_en`, `mem_out_addr = pc`. This is the back-to-back issue path.
  - On `instr_valid & instr_ready`:
    - If a read was issued → CAPTURE, with `instr_valid <= 0`.
    - Otherwise → ISSUE, with `instr_valid <= 0`.
  - If `instr_ready = 0`: stay in HOLD and issue no read.

Branch handling (`branch_en = 1`) has priority over every other transition in any state:
- `pc <= branch_addr`, `instr_valid <= 0`, state → ISSUE.
- `mem_out_en` is forced to 0 that cycle.
- A read that returns during a branch cycle (state CAPTURE) is discarded: `instr_data` and `instr_pc` keep their old values and `pc` is not incremented.
- If a HOLD handshake completes in the same cycle as `branch_en`, the decoder has consumed that instruction. The redirect still applies.

Other rules:
- `run = 0` does not abort a read already in CAPTURE, and does not drop a held instruction.
- `rst` overrides everything, including `branch_en`:
  - `pc <= RESET_PC`, state → ISSUE.
  - `instr_valid <= 0`, `instr_data <= 0`, `instr_pc <= 0`.
  - `mem_out_en` is gated to 0 while `rst` is 1. `mem_out_addr` is don't-care but equals `pc`.
- Reset in the middle of a fetch discards the in-flight read.

## Timing

- Reset values: `instr_valid` 0, `instr_data` 16'h0000, `instr_pc` 16'h0000, `mem_out_en` 0, pc = `RESET_PC`.
- First fetch after reset:
  - `mem_out_en` rises in the first cycle with `rst = 0` and `run = 1` (cycle N).
  - `instr_valid` rises after edge N+1.
  - Latency from issue to valid is 2 edges.
- Sustained throughput with `instr_ready` held at 1: one instruction every 2 cycles. `instr_valid` is high one cycle in every two.
- Branch penalty: from the edge where `branch_en` is sampled to `instr_valid` at `branch_addr` is 2 edges, plus 0 extra if `run = 1`.
- `mem_out_en` and `mem_out_addr` are combinational from state, `pc`, `run`, `branch_en` and `instr_ready`. There is no combinational path from `mem_out_data` to any output.
- `instr_valid`, `instr_data` and `instr_pc` are registered.

## Test plan

- **Reset and linear fetch.** Preload memory with words 0x1111, 0x2222, 0x3333 at addresses 0–2. Apply `rst` for 2 cycles, then `run = 1` and `instr_ready = 1`. Required: instructions delivered in order with `instr_pc` 0, 1, 2, spaced 2 cycles apart; `mem_out_en` is 0 throughout reset.
- **Backpressure.** Hold `instr_ready = 0` for 5 cycles after the first `instr_valid`. Required: `instr_data` stays 0x1111 and `instr_pc` stays 0 for all 5 cycles, no `mem_out_en` pulses occur, and 0x2222 arrives 2 cycles after ready rises.
- **Branch mid-fetch.** Assert `branch_en` with `branch_addr` = 0x0040 (memory[0x40] = 0xBEEF) in a CAPTURE cycle. Required: the returning word is dropped, `instr_valid` stays low, the next delivered instruction is 0xBEEF with `instr_pc` 0x0040, and after it `instr_pc` 0x0041 follows.
- **Branch coincident with handshake.** In HOLD, set `instr_ready = 1` and `branch_en = 1` (target 0x0010) together. Required: no read is issued that cycle, and the next instruction has `instr_pc` 0x0010.
- **PC wrap.** Set `RESET_PC` = 16'hFFFF, with memory[0xFFFF] = 0xAAAA and memory[0] = 0x5555. Required: delivered `instr_pc` sequence 0xFFFF then 0x0000, with matching data.
- **Reset and run gating mid-operation.** Assert `rst` during CAPTURE: `instr_valid` stays 0, and after release fetch restarts at `RESET_PC`. Separately, hold `run = 0` after reset for 4 cycles: `mem_out_en` stays 0 and no instruction is delivered.
